// File: rtl/execute_mdu_if.sv
// EX-stage bus between the pipeline and execute_mdu: forwarding inputs,
// multiply/divide request controls, forwarded operands and HI/LO status.
interface execute_mdu_if;
  logic [31:0] rd1E;
  logic [31:0] rd2E;
  logic [31:0] aluoutM;
  logic [31:0] resultW;
  logic [1:0]  forwardaE;
  logic [1:0]  forwardbE;
  logic        mdstartE;
  logic [1:0]  mdopE;
  logic        flushE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mdbusy;
  logic        mddone;

  modport master (
    output rd1E, rd2E, aluoutM, resultW, forwardaE, forwardbE,
           mdstartE, mdopE, flushE,
    input  srcaE, srcbE, hi, lo, mdbusy, mddone
  );

  modport slave (
    input  rd1E, rd2E, aluoutM, resultW, forwardaE, forwardbE,
           mdstartE, mdopE, flushE,
    output srcaE, srcbE, hi, lo, mdbusy, mddone
  );
endinterface

// File: rtl/execute_mdu.sv
// EX-stage operand forwarding plus a 32-cycle radix-2 multiply/divide unit writing HI/LO.
// Define MDU_DIVIDE_EN to compile in DIV/DIVU; without it divide requests are refused.
module execute_mdu (
  input logic          clk,
  input logic          reset,
  execute_mdu_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mduState;

  mduState     stateReg, stateNext;
  logic [4:0]  countReg;
  logic        signAReg, signBReg;
  logic [31:0] magBReg;
  logic [63:0] workReg, workNext;
  logic [31:0] hiReg, loReg, resHi, resLo;
  logic        doneReg;
  logic        accept, lastIter;
  logic        signedIn, signAIn, signBIn;
  logic [31:0] magAIn, magBIn;
  logic [32:0] sum33;
  logic [63:0] multNext, product;
`ifdef MDU_DIVIDE_EN
  logic        isDivReg;
  logic [31:0] dividendReg;
  logic [32:0] rem33;
  logic [31:0] diff32;
  logic        remGeq;
  logic [63:0] divNext;
  logic [31:0] quot, rem;
`endif

  always_comb begin
    case (bus.forwardaE)
      2'b01:   bus.srcaE = bus.resultW;
      2'b10:   bus.srcaE = bus.aluoutM;
      default: bus.srcaE = bus.rd1E;
    endcase
  end

  always_comb begin
    case (bus.forwardbE)
      2'b01:   bus.srcbE = bus.resultW;
      2'b10:   bus.srcbE = bus.aluoutM;
      default: bus.srcbE = bus.rd2E;
    endcase
  end

`ifdef MDU_DIVIDE_EN
  assign accept = (stateReg == IDLE) && bus.mdstartE && !bus.flushE;
`else
  assign accept = (stateReg == IDLE) && bus.mdstartE && !bus.flushE && !bus.mdopE[1];
`endif
  assign lastIter = (stateReg == RUN) && (countReg == 5'd31);

  // Both algorithms run on magnitudes; signs are reapplied when the result is loaded.
  assign signedIn = ~bus.mdopE[0];
  assign signAIn  = signedIn & bus.srcaE[31];
  assign signBIn  = signedIn & bus.srcbE[31];
  assign magAIn   = signAIn ? -bus.srcaE : bus.srcaE;
  assign magBIn   = signBIn ? -bus.srcbE : bus.srcbE;

  // Shift-add: upper half accumulates, multiplier bits retire from the bottom.
  assign sum33    = {1'b0, workReg[63:32]} + {1'b0, (workReg[0] ? magBReg : 32'd0)};
  assign multNext = {sum33, workReg[31:1]};
  assign product  = (signAReg ^ signBReg) ? -multNext : multNext;

  always_comb begin
    workNext = multNext;
    resHi    = product[63:32];
    resLo    = product[31:0];
`ifdef MDU_DIVIDE_EN
    // Restoring divide: partial remainder in the upper half, quotient bits shift in below.
    rem33   = {workReg[63:32], workReg[31]};
    remGeq  = rem33 >= {1'b0, magBReg};
    diff32  = rem33[31:0] - magBReg;
    divNext = {(remGeq ? diff32 : rem33[31:0]), workReg[30:0], remGeq};
    quot    = (signAReg ^ signBReg) ? -divNext[31:0] : divNext[31:0];
    rem     = signAReg ? -divNext[63:32] : divNext[63:32];
    if (isDivReg) begin
      workNext = divNext;
      if (magBReg == 32'd0) begin
        resHi = dividendReg;
        resLo = 32'hFFFF_FFFF;
      end else begin
        resHi = rem;
        resLo = quot;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (accept) stateNext = RUN;
      RUN:     if (countReg == 5'd31) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    bus.mdbusy = (stateReg == RUN);
    bus.mddone = doneReg;
    bus.hi     = hiReg;
    bus.lo     = loReg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      countReg    <= 5'd0;
      signAReg    <= 1'b0;
      signBReg    <= 1'b0;
      magBReg     <= 32'd0;
      workReg     <= 64'd0;
      hiReg       <= 32'd0;
      loReg       <= 32'd0;
      doneReg     <= 1'b0;
`ifdef MDU_DIVIDE_EN
      isDivReg    <= 1'b0;
      dividendReg <= 32'd0;
`endif
    end else begin
      doneReg <= lastIter;
      if (accept) begin
        countReg    <= 5'd0;
        signAReg    <= signAIn;
        signBReg    <= signBIn;
        magBReg     <= magBIn;
        workReg     <= {32'd0, magAIn};
`ifdef MDU_DIVIDE_EN
        isDivReg    <= bus.mdopE[1];
        dividendReg <= bus.srcaE;
`endif
      end else if (stateReg == RUN) begin
        countReg <= countReg + 5'd1;
        workReg  <= workNext;
        if (lastIter) begin
          hiReg <= resHi;
          loReg <= resLo;
        end
      end
    end
  end
endmodule

// File: tb/tb_execute_mdu.sv
// Directed bench for execute_mdu: forwarding checks plus multiply/divide operations
// scored by a queue-based monitor that compares HI/LO on every mddone pulse.
module tb_execute_mdu;
  logic clk;
  logic reset;
  execute_mdu_if bus ();

  execute_mdu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          assertCount = 0;
  int          failCount   = 0;
  logic [63:0] expQ[$];
  string       nameQ[$];
  logic [63:0] lastRes = 64'd0;
  logic [63:0] monExp;
  string       monName;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    assertCount++;
    if (got !== req) begin
      failCount++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Monitor: every completion pulse is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.mddone === 1'b1) begin
      assertCount++;
      if (expQ.size() == 0) begin
        failCount++;
        $display("FAIL unexpected_mddone: got hi=%h lo=%h, required no completion", bus.hi, bus.lo);
      end else begin
        monExp  = expQ.pop_front();
        monName = nameQ.pop_front();
        if ({bus.hi, bus.lo} !== monExp) begin
          failCount++;
          $display("FAIL %s: got hi=%h lo=%h, required hi=%h lo=%h",
                   monName, bus.hi, bus.lo, monExp[63:32], monExp[31:0]);
        end else begin
          $display("ok   %s: hi=%h lo=%h", monName, bus.hi, bus.lo);
        end
      end
    end
  end

  task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit fwd, input int injectAt,
                       input logic [63:0] exp);
    int busy;
    bit done;
    if (fwd) begin
      bus.rd1E      = 32'hDEAD0001;
      bus.rd2E      = 32'hDEAD0002;
      bus.aluoutM   = a;
      bus.resultW   = b;
      bus.forwardaE = 2'b10;
      bus.forwardbE = 2'b01;
    end else begin
      bus.rd1E      = a;
      bus.rd2E      = b;
      bus.forwardaE = 2'b00;
      bus.forwardbE = 2'b00;
    end
    bus.mdopE    = op;
    bus.flushE   = 1'b0;
    bus.mdstartE = 1'b1;
    expQ.push_back(exp);
    nameQ.push_back(name);
    lastRes = exp;
    @(posedge clk);
    #1;
    bus.mdstartE = 1'b0;
    busy = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      bus.mdstartE = 1'b0;
      if (bus.mddone === 1'b1) begin
        done = 1'b1;
        check({name, "_busy_in_done"}, 64'(bus.mdbusy), 64'd0);
      end else if (bus.mdbusy === 1'b1) begin
        busy++;
        if (busy == injectAt) begin
          bus.rd1E      = 32'd100;
          bus.rd2E      = 32'd100;
          bus.forwardaE = 2'b00;
          bus.forwardbE = 2'b00;
          bus.mdopE     = 2'b01;
          bus.mdstartE  = 1'b1;
        end
      end
    end
    check({name, "_busy_cycles"}, 64'(busy), 64'd32);
    check({name, "_done_seen"}, 64'(done), 64'd1);
  endtask

  initial begin
    int cnt;
    int doneCnt;
    bus.rd1E      = 32'd0;
    bus.rd2E      = 32'd0;
    bus.aluoutM   = 32'd0;
    bus.resultW   = 32'd0;
    bus.forwardaE = 2'b00;
    bus.forwardbE = 2'b00;
    bus.mdstartE  = 1'b0;
    bus.mdopE     = 2'b00;
    bus.flushE    = 1'b0;
    reset         = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    check("reset_busy", 64'(bus.mdbusy), 64'd0);
    check("reset_done", 64'(bus.mddone), 64'd0);
    reset = 1'b0;

    // Forwarding mux, all four select codes on both sides.
    bus.rd1E = 32'd0; bus.aluoutM = 32'h1234; bus.forwardaE = 2'b10;
    bus.rd2E = 32'h5555AAAA; bus.forwardbE = 2'b11;
    #1;
    check("fwd_a_mem", 64'(bus.srcaE), 64'h1234);
    check("fwd_b_rd11", 64'(bus.srcbE), 64'h5555AAAA);
    bus.resultW = 32'hCAFEF00D; bus.forwardaE = 2'b01; bus.forwardbE = 2'b10;
    #1;
    check("fwd_a_wb", 64'(bus.srcaE), 64'hCAFEF00D);
    check("fwd_b_mem", 64'(bus.srcbE), 64'h1234);
    bus.rd1E = 32'h13579BDF; bus.forwardaE = 2'b00; bus.forwardbE = 2'b01;
    #1;
    check("fwd_a_rd", 64'(bus.srcaE), 64'h13579BDF);
    check("fwd_b_wb", 64'(bus.srcbE), 64'hCAFEF00D);
    bus.forwardaE = 2'b11;
    #1;
    check("fwd_a_rd11", 64'(bus.srcaE), 64'h13579BDF);
    @(negedge clk);

    // Consecutive calls also start each op in the previous op's mddone cycle.
    runOp("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, -1, 64'hFFFFFFFF_FFFFFFEB);
    runOp("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, 64'hFFFFFFFE_00000001);
    runOp("mult_fwd_min", 2'b00, 32'h80000000, 32'h80000000, 1'b1, -1, 64'h40000000_00000000);
    runOp("multu_inject", 2'b01, 32'd3, 32'd5, 1'b0, 5, 64'h00000000_0000000F);

    // A flushed request must not start the unit.
    bus.rd1E = 32'd9; bus.rd2E = 32'd9; bus.forwardaE = 2'b00; bus.forwardbE = 2'b00;
    bus.mdopE = 2'b00; bus.flushE = 1'b1; bus.mdstartE = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.mdbusy !== 1'b0) cnt++;
    end
    bus.mdstartE = 1'b0; bus.flushE = 1'b0;
    check("flush_busy_cycles", 64'(cnt), 64'd0);
    check("flush_hilo", {bus.hi, bus.lo}, lastRes);

`ifdef MDU_DIVIDE_EN
    runOp("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, -1, 64'hFFFFFFFF_FFFFFFFD);
    runOp("div_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 1'b0, -1, 64'h00000001_FFFFFFFD);
    runOp("divu_100_0", 2'b11, 32'd100, 32'd0, 1'b0, -1, 64'h00000064_FFFFFFFF);
    runOp("div_m5_0", 2'b10, 32'hFFFFFFFB, 32'd0, 1'b0, -1, 64'hFFFFFFFB_FFFFFFFF);
    runOp("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1, 64'h00000000_80000000);
    runOp("divu_max_3", 2'b11, 32'hFFFFFFFF, 32'd3, 1'b0, -1, 64'h00000000_55555555);
`else
    bus.rd1E = 32'd7; bus.rd2E = 32'd2; bus.mdopE = 2'b10; bus.mdstartE = 1'b1;
    cnt = 0;
    doneCnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mdbusy !== 1'b0) cnt++;
      if (bus.mddone !== 1'b0) doneCnt++;
    end
    bus.mdstartE = 1'b0;
    check("div_disabled_busy", 64'(cnt), 64'd0);
    check("div_disabled_done", 64'(doneCnt), 64'd0);
    check("div_disabled_hilo", {bus.hi, bus.lo}, lastRes);
    runOp("multu_after_div", 2'b01, 32'd6, 32'd7, 1'b0, -1, 64'h00000000_0000002A);
`endif

    // Reset in the middle of an operation abandons it with no completion.
    bus.rd1E = 32'd3; bus.rd2E = 32'd5; bus.forwardaE = 2'b00; bus.forwardbE = 2'b00;
    bus.mdopE = 2'b01; bus.mdstartE = 1'b1;
    @(posedge clk);
    #1;
    bus.mdstartE = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 10; i++) begin
      @(negedge clk);
      if (bus.mdbusy === 1'b1) cnt++;
    end
    check("rst_run_reached_10", 64'(cnt), 64'd10);
    #2 reset = 1'b1;
    #1;
    check("rst_run_busy", 64'(bus.mdbusy), 64'd0);
    check("rst_run_done", 64'(bus.mddone), 64'd0);
    check("rst_run_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mddone !== 1'b0) doneCnt++;
    end
    check("rst_run_no_done", 64'(doneCnt), 64'd0);
    check("scoreboard_drained", 64'(expQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/execute_mdu.md
EXECUTE_MDU -- requirements
Module: execute_mdu

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Ports SHALL be:
- clk  in  1  pipeline clock
- reset  in  1  async active-high reset
- rd1E, rd2E  in  32  register-file operands in EX
- aluoutM  in  32  MEM-stage forward value
- resultW  in  32  WB-stage forward value
- forwardaE, forwardbE  in  2  forward selects from hazard unit
- mdstartE  in  1  multiply/divide request in EX
- mdopE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- flushE  in  1  EX bubble from hazard unit
- srcaE, srcbE  out  32  forwarded operands
- hi, lo  out  32  HI/LO result registers
- mdbusy  out  1  unit running, to hazard unit as stall source
- mddone  out  1  one-cycle completion pulse

Function
REQ-003 srcaE SHALL be combinational: forwardaE 00 -> rd1E, 01 -> resultW, 10 -> aluoutM, 11 -> rd1E; srcbE identical using forwardbE/rd2E.
REQ-004 FSM states SHALL be IDLE and RUN, with a 5-bit iteration counter.
REQ-005 A request SHALL be accepted on an edge where state=IDLE, mdstartE=1 and flushE=0; srcaE/srcbE/mdopE are captured at that edge.
REQ-006 mdstartE with flushE=1, or while state=RUN, SHALL be ignored with no state change.
REQ-007 After acceptance state SHALL be RUN for exactly 32 cycles with mdbusy=1; one radix-2 iteration (shift-add or restoring subtract) per cycle.
REQ-008 On the 32nd RUN edge hi/lo SHALL load the result, state returns to IDLE, and mddone=1 for the following single cycle (cycle 33 after acceptance); mdbusy=0 in that cycle.
REQ-009 A new request SHALL be accepted in the same cycle mddone=1.
REQ-010 MULT/MULTU: {hi,lo} SHALL be the 64-bit signed/unsigned product.
REQ-011 DIV/DIVU: lo SHALL be quotient and hi remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-012 Divide by zero SHALL give lo=32'hFFFFFFFF, hi=dividend (both signedness).
REQ-013 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0.
REQ-014 hi/lo SHALL change only at completion (REQ-008) or reset.

Reset
REQ-015 reset SHALL force state=IDLE, counter=0, hi=0, lo=0, mdbusy=0, mddone=0, captured operands=0, asynchronously.
REQ-016 reset asserted during RUN SHALL abandon the operation; no mddone pulse, hi/lo read 0.

Configuration
REQ-017 Macro MDU_DIVIDE_EN SHALL compile in divide support.
REQ-018 With MDU_DIVIDE_EN defined, DIV/DIVU SHALL behave per REQ-011..013.
REQ-019 Without MDU_DIVIDE_EN, mdopE 10/11 requests SHALL not be accepted: no busy, no mddone, hi/lo unchanged; multiply and forwarding unaffected.

Verification
REQ-020 Bench SHALL cover:
- forwardaE=10, aluoutM=32'h1234, rd1E=0 -> srcaE=32'h1234; forwardbE=11 -> srcbE=rd2E.
- MULT srcaE=-3 (32'hFFFFFFFD), srcbE=7 -> mdbusy 32 cycles, cycle 33 mddone=1, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
- DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 100/0 -> lo=32'hFFFFFFFF, hi=100.
- mdstartE with flushE=1 -> mdbusy stays 0; mdstartE during RUN -> ignored, hi/lo from first op only.
- reset pulsed at RUN cycle 10 -> mdbusy=0 immediately, hi=lo=0, no mddone; build without MDU_DIVIDE_EN, DIV request -> mdbusy never asserts.
